// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, NOP encoding, next-PC select codes and fetch state.
package cpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP = 16'h0000;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // Only branch and jump move the PC off the sequential path; code 3 behaves like PC_SEQ.
  function automatic logic is_redirect(input logic [1:0] sel);
    return (sel == PC_BRANCH) || (sel == PC_JUMP);
  endfunction

endpackage

// File: rtl/program_counter.sv
// PC register with the PC+2 adder, next-PC select and stall gating.
module program_counter
  import cpu_pkg::PC_BRANCH, cpu_pkg::PC_JUMP;
#(
  parameter int                ADDR_W       = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              freeze_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [1:0]        pc_mux_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus2_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  assign pc_plus2_o = pc_q + ADDR_W'(2);
  assign pc_o       = pc_q;

  // A redirect beats a stall, and a flush also releases the stall hold.
  always_comb begin
    pc_d = pc_q;
    if (freeze_i) begin
      pc_d = pc_q;
    end else if (pc_mux_i == PC_BRANCH) begin
      pc_d = branch_target_i;
    end else if (pc_mux_i == PC_JUMP) begin
      pc_d = jump_target_i;
    end else if (stall_i && !flush_i) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_plus2_o;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IF/ID buffer and RUN/STALL/HALT control.
// Optional stall/flush performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import cpu_pkg::NOP, cpu_pkg::fetch_state_e, cpu_pkg::ST_RUN, cpu_pkg::ST_STALL,
         cpu_pkg::ST_HALT, cpu_pkg::is_redirect;
#(
  parameter int                ADDR_W       = cpu_pkg::ADDR_W,
  parameter int                INSTR_W      = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               if_pc_stop,
  input  logic               if_id_buffer_flush,
  input  logic [1:0]         if_pc_mux,
  input  logic [ADDR_W-1:0]  ex_if_branch_location_result,
  input  logic [ADDR_W-1:0]  id_jump_target,
  input  logic               ctrl_id_halt,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  if_address_from_pc,
  output logic [INSTR_W-1:0] id_instruction,
  output logic [ADDR_W-1:0]  id_pc_next_address,
  output logic               id_valid,
  output logic               halted,
  output logic [15:0]        stall_count,
  output logic [15:0]        flush_count,
  output logic [1:0]         dbg_state
);

  fetch_state_e       state_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  npc_q;
  logic               valid_q;
  logic               halted_q;
  logic [ADDR_W-1:0]  pc_plus2;
  logic               active;
  logic               redirect;

  // Once halted (or halting this edge) nothing else may move the pipeline.
  assign active   = (state_q != ST_HALT) && !ctrl_id_halt;
  assign redirect = is_redirect(if_pc_mux);

  program_counter #(
    .ADDR_W       (ADDR_W),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .clock_i         (clock),
    .reset_i         (reset),
    .freeze_i        (!active),
    .stall_i         (if_pc_stop),
    .flush_i         (if_id_buffer_flush),
    .pc_mux_i        (if_pc_mux),
    .branch_target_i (ex_if_branch_location_result),
    .jump_target_i   (id_jump_target),
    .pc_o            (if_address_from_pc),
    .pc_plus2_o      (pc_plus2)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      instr_q  <= '0;
      npc_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_HALT: begin
          instr_q  <= INSTR_W'(NOP);
          npc_q    <= '0;
          valid_q  <= 1'b0;
          halted_q <= 1'b1;
        end
        default: begin
          if (ctrl_id_halt) begin
            state_q  <= ST_HALT;
            instr_q  <= INSTR_W'(NOP);
            npc_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
          end else if (if_id_buffer_flush) begin
            state_q <= ST_RUN;
            instr_q <= INSTR_W'(NOP);
            npc_q   <= '0;
            valid_q <= 1'b0;
          end else if (if_pc_stop && !redirect) begin
            state_q <= ST_STALL;
          end else begin
            // Plain advance, or a redirect without flush keeping the fetched slot.
            state_q <= ST_RUN;
            instr_q <= imem_data;
            npc_q   <= pc_plus2;
            valid_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign id_instruction     = instr_q;
  assign id_pc_next_address = npc_q;
  assign id_valid           = valid_q;
  assign halted             = halted_q;
  assign dbg_state          = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;
  logic        stall_edge;
  logic        flush_edge;

  assign stall_edge = active && if_pc_stop && !redirect && !if_id_buffer_flush;
  assign flush_edge = active && if_id_buffer_flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_edge && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_edge && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = 16'h0000;
  assign flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, async-reset-in-halt sequence, randomized run vs reference model.
module tb_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        if_pc_stop;
  logic        if_id_buffer_flush;
  logic [1:0]  if_pc_mux;
  logic [15:0] ex_if_branch_location_result;
  logic [15:0] id_jump_target;
  logic        ctrl_id_halt;
  logic [15:0] imem_data;
  logic [15:0] if_address_from_pc;
  logic [15:0] id_instruction;
  logic [15:0] id_pc_next_address;
  logic        id_valid;
  logic        halted;
  logic [15:0] stall_count;
  logic [15:0] flush_count;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit dut (
    .clock                        (clock),
    .reset                        (reset),
    .if_pc_stop                   (if_pc_stop),
    .if_id_buffer_flush           (if_id_buffer_flush),
    .if_pc_mux                    (if_pc_mux),
    .ex_if_branch_location_result (ex_if_branch_location_result),
    .id_jump_target               (id_jump_target),
    .ctrl_id_halt                 (ctrl_id_halt),
    .imem_data                    (imem_data),
    .if_address_from_pc           (if_address_from_pc),
    .id_instruction               (id_instruction),
    .id_pc_next_address           (id_pc_next_address),
    .id_valid                     (id_valid),
    .halted                       (halted),
    .stall_count                  (stall_count),
    .flush_count                  (flush_count),
    .dbg_state                    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- instruction memory ----------------
  function automatic logic [15:0] imem_fn(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0002) return 16'h5678;
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  always_comb imem_data = imem_fn(if_address_from_pc);

  // ---------------- checking ----------------
  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic stop, input logic flush, input logic [1:0] mux,
                       input logic [15:0] br, input logic [15:0] jt, input logic halt);
    if_pc_stop                   = stop;
    if_id_buffer_flush           = flush;
    if_pc_mux                    = mux;
    ex_if_branch_location_result = br;
    id_jump_target               = jt;
    ctrl_id_halt                 = halt;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        stop;
    logic        flush;
    logic [1:0]  mux;
    logic [15:0] br;
    logic [15:0] jt;
    logic        halt;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
    logic [15:0] e_npc;
    logic        e_valid;
    logic        e_halted;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input string name, input logic stop, input logic flush,
                              input logic [1:0] mux, input logic [15:0] br, input logic [15:0] jt,
                              input logic halt, input logic [15:0] e_pc, input logic [15:0] e_instr,
                              input logic [15:0] e_npc, input logic e_valid, input logic e_halted);
    vec_t v;
    v.name = name; v.stop = stop; v.flush = flush; v.mux = mux; v.br = br; v.jt = jt;
    v.halt = halt; v.e_pc = e_pc; v.e_instr = e_instr; v.e_npc = e_npc;
    v.e_valid = e_valid; v.e_halted = e_halted;
    return v;
  endfunction

  // ---------------- reference model ----------------
  logic [15:0] m_pc, m_instr, m_npc, m_sc, m_fc;
  logic        m_valid, m_halted;

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_npc = 16'h0000;
    m_valid = 1'b0; m_halted = 1'b0; m_sc = 16'h0000; m_fc = 16'h0000;
  endtask

  // One clock edge of fetch behaviour, applied in priority order halt > redirect/flush > stall > advance.
  task automatic model_step(input logic stop, input logic flush, input logic [1:0] mux,
                            input logic [15:0] br, input logic [15:0] jt, input logic halt);
    logic        redirect;
    logic [15:0] seq;
    if (m_halted) return;
    if (halt) begin
      m_halted = 1'b1; m_instr = 16'h0000; m_npc = 16'h0000; m_valid = 1'b0;
      return;
    end
    redirect = (mux == 2'd1) || (mux == 2'd2);
    seq = m_pc + 16'd2;
    if (flush) begin
      m_instr = 16'h0000; m_npc = 16'h0000; m_valid = 1'b0;
      if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
    end else if (stop && !redirect) begin
      if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
    end else begin
      m_instr = imem_fn(m_pc); m_npc = seq; m_valid = 1'b1;
    end
    if (mux == 2'd1)               m_pc = br;
    else if (mux == 2'd2)          m_pc = jt;
    else if (!(stop && !flush))    m_pc = seq;
  endtask

  // ---------------- main test ----------------
  initial begin
    vecs[0]  = mk("run0",     0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0002, 16'h1234, 16'h0002, 1, 0);
    vecs[1]  = mk("run1",     0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0004, 16'h5678, 16'h0004, 1, 0);
    vecs[2]  = mk("stall0",   1, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0004, 16'h5678, 16'h0004, 1, 0);
    vecs[3]  = mk("stall1",   1, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0004, 16'h5678, 16'h0004, 1, 0);
    vecs[4]  = mk("stall2",   1, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0004, 16'h5678, 16'h0004, 1, 0);
    vecs[5]  = mk("release",  0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0006, imem_fn(16'h0004), 16'h0006, 1, 0);
    vecs[6]  = mk("br_flush", 1, 1, 2'd1, 16'h0040, 16'h0000, 0, 16'h0040, 16'h0000, 16'h0000, 0, 0);
    vecs[7]  = mk("jump",     0, 0, 2'd2, 16'h0000, 16'h0100, 0, 16'h0100, imem_fn(16'h0040), 16'h0042, 1, 0);
    vecs[8]  = mk("after_j",  0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0102, imem_fn(16'h0100), 16'h0102, 1, 0);
    vecs[9]  = mk("jmp_top",  0, 0, 2'd2, 16'h0000, 16'hFFFE, 0, 16'hFFFE, imem_fn(16'h0102), 16'h0104, 1, 0);
    vecs[10] = mk("wrap",     0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0000, imem_fn(16'hFFFE), 16'h0000, 1, 0);
    vecs[11] = mk("mux3",     0, 0, 2'd3, 16'h0200, 16'h0300, 0, 16'h0002, 16'h1234, 16'h0002, 1, 0);
    vecs[12] = mk("run_a",    0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0004, 16'h5678, 16'h0004, 1, 0);
    vecs[13] = mk("run_b",    0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0006, imem_fn(16'h0004), 16'h0006, 1, 0);
    vecs[14] = mk("run_c",    0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0008, imem_fn(16'h0006), 16'h0008, 1, 0);
    vecs[15] = mk("halt",     0, 0, 2'd0, 16'h0000, 16'h0000, 1, 16'h0008, 16'h0000, 16'h0000, 0, 1);
    vecs[16] = mk("halt_br",  0, 1, 2'd1, 16'h0040, 16'h0000, 0, 16'h0008, 16'h0000, 16'h0000, 0, 1);
    vecs[17] = mk("halt_jmp", 1, 0, 2'd2, 16'h0000, 16'h0100, 0, 16'h0008, 16'h0000, 16'h0000, 0, 1);
    vecs[18] = mk("halt_seq", 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0008, 16'h0000, 16'h0000, 0, 1);
    vecs[19] = mk("halt_fl",  0, 1, 2'd0, 16'h0000, 16'h0000, 1, 16'h0008, 16'h0000, 16'h0000, 0, 1);
    vecs[20] = mk("halt_br2", 1, 1, 2'd1, 16'h0040, 16'h0000, 0, 16'h0008, 16'h0000, 16'h0000, 0, 1);

    reset = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check16("rst_pc", if_address_from_pc, 16'h0000);
    check16("rst_instr", id_instruction, 16'h0000);
    check16("rst_npc", id_pc_next_address, 16'h0000);
    check1("rst_valid", id_valid, 1'b0);
    check1("rst_halted", halted, 1'b0);
    check16("rst_stall_cnt", stall_count, 16'h0000);
    check16("rst_flush_cnt", flush_count, 16'h0000);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].stop, vecs[i].flush, vecs[i].mux, vecs[i].br, vecs[i].jt, vecs[i].halt);
      @(posedge clock);
      #1;
      check16({vecs[i].name, "_pc"}, if_address_from_pc, vecs[i].e_pc);
      check16({vecs[i].name, "_instr"}, id_instruction, vecs[i].e_instr);
      check16({vecs[i].name, "_npc"}, id_pc_next_address, vecs[i].e_npc);
      check1({vecs[i].name, "_valid"}, id_valid, vecs[i].e_valid);
      check1({vecs[i].name, "_halted"}, halted, vecs[i].e_halted);
      if (i == 5) check16("stall_count_3", stall_count, CNT_EN ? 16'd3 : 16'd0);
      if (i == 6) check16("flush_count_1", flush_count, CNT_EN ? 16'd1 : 16'd0);
    end
    check16("halt_stall_cnt", stall_count, CNT_EN ? 16'd3 : 16'd0);
    check16("halt_flush_cnt", flush_count, CNT_EN ? 16'd1 : 16'd0);

    // Asynchronous reset in the middle of a cycle while halted.
    #2;
    reset = 1'b0;
    #1;
    check16("async_rst_pc", if_address_from_pc, 16'h0000);
    check1("async_rst_halted", halted, 1'b0);
    check1("async_rst_valid", id_valid, 1'b0);
    check16("async_rst_flush_cnt", flush_count, 16'h0000);
    @(negedge clock);
    reset = 1'b1;

    // Randomized run against the reference model.
    model_reset();
    for (int n = 0; n < 600; n++) begin
      logic        r_stop, r_flush, r_halt;
      logic [1:0]  r_mux;
      logic [15:0] r_br, r_jt;
      int unsigned r;
      if (m_halted && ($urandom_range(0, 7) == 0)) begin
        do_reset();
        model_reset();
        continue;
      end
      r       = $urandom_range(0, 9);
      r_mux   = (r < 6) ? 2'd0 : 2'(r - 6);
      r_stop  = ($urandom_range(0, 3) == 0);
      r_flush = ($urandom_range(0, 5) == 0);
      r_halt  = ($urandom_range(0, 59) == 0);
      r_br    = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE;
      r_jt    = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE;
      drive(r_stop, r_flush, r_mux, r_br, r_jt, r_halt);
      model_step(r_stop, r_flush, r_mux, r_br, r_jt, r_halt);
      @(posedge clock);
      #1;
      check16("rnd_pc", if_address_from_pc, m_pc);
      check16("rnd_instr", id_instruction, m_instr);
      check16("rnd_npc", id_pc_next_address, m_npc);
      check1("rnd_valid", id_valid, m_valid);
      check1("rnd_halted", halted, m_halted);
      check16("rnd_stall_cnt", stall_count, CNT_EN ? m_sc : 16'h0000);
      check16("rnd_flush_cnt", flush_count, CNT_EN ? m_fc : 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage pipelined CPU. It holds the program counter, drives the instruction-memory address, selects the next PC (sequential, branch, or jump), and owns the IF/ID pipeline buffer. It applies hazard-unit stalls and control-unit flushes and halts, and feeds the decode stage with `id_instruction` and `id_pc_next_address`.

## Interface
- `ADDR_W`, default 16: PC and instruction-memory address width.
- `INSTR_W`, default 16: instruction width.
- `RESET_VECTOR`, default 16'h0000: PC value after reset.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `if_pc_stop` in 1: hazard-unit stall; freeze the PC and hold IF/ID.
- `if_id_buffer_flush` in 1: squash the instruction now in IF; load a NOP into IF/ID.
- `if_pc_mux` in 2: next-PC select. 0 = PC+2, 1 = branch target, 2 = jump target, 3 = reserved (treated as 0).
- `ex_if_branch_location_result` in ADDR_W: branch target.
- `id_jump_target` in ADDR_W: jump target.
- `ctrl_id_halt` in 1: halt request from the control unit.
- `imem_data` in INSTR_W: combinational instruction-memory read data.
- `if_address_from_pc` out ADDR_W: current PC, which is also the imem address.
- `id_instruction` out INSTR_W: IF/ID instruction.
- `id_pc_next_address` out ADDR_W: IF/ID copy of PC+2.
- `id_valid` out 1: IF/ID holds a real instruction.
- `halted` out 1: fetch is in the HALT state.
- `stall_count` out 16: stall-cycle counter (see Configuration).
- `flush_count` out 16: flush counter (see Configuration).

## Operation
- States are RUN, STALL and HALT. Reset enters RUN.
- **PC+2:** unsigned, modulo 2^ADDR_W. 16'hFFFE wraps to 16'h0000 with no flag.
- **Priority each edge:** halt > redirect/flush > stall > advance.
- **HALT:**
  - Entered from any state when `ctrl_id_halt`=1.
  - PC is frozen. IF/ID loads NOP (16'h0000) with `id_valid`=0, and `halted`=1.
  - HALT is left only by reset. All other inputs are ignored.
- **Redirect** (`if_pc_mux`=1 or 2):
  - PC loads the selected target.
  - This overrides a stall asserted in the same cycle. The state returns to RUN.
- **Flush** (`if_id_buffer_flush`=1):
  - IF/ID loads NOP with `id_valid`=0.
  - The PC update still follows `if_pc_mux`.
  - Flush overrides stall, so the IF/ID hold does not apply.
- **STALL** (`if_pc_stop`=1, no redirect or flush):
  - PC and IF/ID retain their values.
  - The state is STALL for as long as the stall is asserted, then returns to RUN.
- **RUN advance:**
  - PC loads PC+2.
  - IF/ID loads `imem_data`, PC+2, and `id_valid`=1.

## Timing
- **Reset values** (asynchronous, while `reset`=0):
  - PC = RESET_VECTOR.
  - `id_instruction`=0, `id_pc_next_address`=0, `id_valid`=0.
  - `halted`=0, both counters 0, state RUN.
- **Latency:** an instruction at PC appears on `id_instruction` one edge after PC is presented. A redirect takes effect on the PC one edge after `if_pc_mux` is sampled.
- **Taken-branch cost:** the control unit must assert flush in the same cycle as the redirect, which costs one bubble.
- **Output timing:** all outputs are registered except `if_address_from_pc`, which is the PC register output.
- **Reset release:** the first fetch is from RESET_VECTOR on the first rising edge after `reset` rises.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `stall_count` increments on every edge that the state is STALL.
  - `flush_count` increments on every flush edge.
  - Both are 16-bit and saturate at 16'hFFFF. Both are cleared by reset. Neither counts while HALT.
- `FETCH_PERF_CNT_EN` undefined: no counter registers exist, and both outputs are tied to 0.

## Structure
- **Shared package** (`cpu_pkg`) holds:
  - ADDR_W and INSTR_W.
  - The NOP encoding.
  - PC_MUX encodings: PC_SEQ=0, PC_BRANCH=1, PC_JUMP=2.
  - The fetch state enum.
- **Sub-module** `program_counter`: the PC register, the PC+2 adder, the next-PC mux and stall gating. The IF/ID buffer and FSM stay in `fetch_unit`.

## Test plan
- **Reset then run:** `reset` 0→1, `imem_data` = 16'h1234 at 0 and 16'h5678 at 2.
  - PC goes 0, 2, 4.
  - `id_instruction` goes 1234 then 5678, with `id_valid`=1.
  - `id_pc_next_address` goes 2 then 4.
- **Stall:** at PC=4, `if_pc_stop`=1 for 3 cycles.
  - PC stays 4 and IF/ID is unchanged for 3 edges.
  - With the counter enabled, `stall_count`=3.
  - PC=6 on the edge after release.
- **Branch with flush and simultaneous stall:** at PC=6, `if_pc_mux`=1, target=16'h0040, flush=1, `if_pc_stop`=1.
  - Next PC is 16'h0040.
  - `id_valid`=0 and `id_instruction`=0000.
  - `flush_count`=1.
- **Jump:** `if_pc_mux`=2, `id_jump_target`=16'h0100 → PC=16'h0100 next edge.
- **Wrap:** PC=16'hFFFE, sequential → PC=16'h0000.
- **Halt, then reset mid-halt:** `ctrl_id_halt`=1 at PC=8.
  - `halted`=1 and PC stays 8 for 5 cycles, despite redirects.
  - Asserting `reset`=0 asynchronously mid-cycle returns PC to 0 and `halted` to 0 immediately.
